// File: rtl/bpred_btb_pkg.sv
// Shared types for the fetch-side branch predictor / BTB: feedback and result
// records, table entry layout and 2-bit counter encodings.
package bpred_btb_pkg;

  typedef logic [31:0] Address;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic   fb_taken;
    logic   fb_not_taken;
    Address fb_pc;
    Address jump_vec;
  } Branch_control;

  // Tag is held right-aligned in the widest possible field (index is >= 1 bit).
  typedef struct packed {
    logic        valid;
    logic [30:0] tag;
    Address      target;
    logic [1:0]  ctr;
  } Bpred_entry;

  typedef struct packed {
    logic   valid;
    Address pc;
    logic   taken;
    Address npc;
    logic   hit;
  } Bpred_result;

  function automatic logic [30:0] tag_of(input Address pc, input int idx_w);
    return 31'(pc >> idx_w);
  endfunction

endpackage

// File: rtl/bpred_ctr2.sv
// Two-bit saturating counter next-state; increment takes priority over decrement.
module bpred_ctr2
  import bpred_btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else if (dec) begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Direct-mapped BTB with 2-bit direction counters; registered one-cycle lookup,
// training from branch resolution feedback, single-edge invalidate on reset.
module bpred_btb
  import bpred_btb_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_valid,
  input  Address        fetch_pc,
  input  logic          flush,
  input  Branch_control fb,
  output Bpred_result   pred
);

  // Flop array: every valid bit must clear on the same edge, so no RAM here.
  Bpred_entry tab [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] fb_idx;
  logic             lk_hit;
  logic             lk_taken;
  logic             fb_hit;
  logic [1:0]       ctr_next;

  assign lk_idx   = fetch_pc[IDX_W-1:0];
  assign fb_idx   = fb.fb_pc[IDX_W-1:0];
  assign lk_hit   = tab[lk_idx].valid && (tab[lk_idx].tag == tag_of(fetch_pc, IDX_W));
  assign lk_taken = lk_hit && tab[lk_idx].ctr[1];
  assign fb_hit   = tab[fb_idx].valid && (tab[fb_idx].tag == tag_of(fb.fb_pc, IDX_W));

  bpred_ctr2 u_ctr (
    .ctr      (tab[fb_idx].ctr),
    .inc      (fb.fb_taken),
    .dec      (fb.fb_not_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) tab[i].valid <= 1'b0;
    end else if (fb.fb_taken) begin
      if (fb_hit) begin
        tab[fb_idx].target <= fb.jump_vec;
        tab[fb_idx].ctr    <= ctr_next;
      end else begin
        tab[fb_idx].valid  <= 1'b1;
        tab[fb_idx].tag    <= tag_of(fb.fb_pc, IDX_W);
        tab[fb_idx].target <= fb.jump_vec;
        tab[fb_idx].ctr    <= CTR_WT;
      end
    end else if (fb.fb_not_taken && fb_hit) begin
      tab[fb_idx].ctr <= ctr_next;
    end
  end

  // Lookup reads the table before this edge's training write lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pred <= '0;
    end else begin
      pred.valid <= fetch_valid && !flush;
      pred.pc    <= fetch_pc;
      pred.taken <= lk_taken;
      pred.npc   <= lk_taken ? tab[lk_idx].target : fetch_pc + 32'd1;
      pred.hit   <= lk_hit;
    end
  end

  a_fb_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(fb.fb_taken && fb.fb_not_taken));

endmodule

// File: tb/tb_bpred_btb.sv
// Bench for bpred_btb: directed vector table with hand-derived results, then
// randomized traffic checked against an array-based reference model.
module tb_bpred_btb;
  import bpred_btb_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_valid;
  Address        fetch_pc;
  logic          flush;
  Branch_control fb;
  Bpred_result   pred;

  int n_cmp = 0;
  int n_bad = 0;

  bpred_btb #(.ENTRIES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .flush       (flush),
    .fb          (fb),
    .pred        (pred)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     rst;
    bit     fv;
    Address pc;
    bit     fl;
    bit     ft;
    bit     fnt;
    Address fpc;
    Address jv;
    bit     ev;
    bit     eh;
    bit     et;
    Address enpc;
  } vec_t;

  vec_t vecs [$];

  // Reference model: 16 entries, full pc remembered, counter as plain integer.
  bit     m_valid  [16];
  Address m_pc     [16];
  Address m_target [16];
  int     m_ctr    [16];

  function automatic bit m_hit(input Address pc);
    int i = int'(pc % 32'd16);
    return m_valid[i] && ((m_pc[i] / 32'd16) == (pc / 32'd16));
  endfunction

  function automatic Bpred_result m_step(input bit rst, input bit fv, input Address pc,
                                         input bit fl, input bit ft, input bit fnt,
                                         input Address fpc, input Address jv);
    Bpred_result r = '0;
    int i;
    if (!rst) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
      return r;
    end
    i = int'(pc % 32'd16);
    r.valid = fv && !fl;
    r.pc    = pc;
    r.hit   = m_hit(pc);
    r.taken = r.hit && (m_ctr[i] >= 2);
    r.npc   = r.taken ? m_target[i] : pc + 32'd1;
    i = int'(fpc % 32'd16);
    if (ft) begin
      if (m_hit(fpc)) begin
        m_target[i] = jv;
        m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      end else begin
        m_valid[i] = 1'b1;
        m_pc[i] = fpc;
        m_target[i] = jv;
        m_ctr[i] = 2;
      end
    end else if (fnt && m_hit(fpc)) begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end
    return r;
  endfunction

  task automatic drive(input bit rst, input bit fv, input Address pc, input bit fl,
                       input bit ft, input bit fnt, input Address fpc, input Address jv);
    reset           = rst;
    fetch_valid     = fv;
    fetch_pc        = pc;
    flush           = fl;
    fb.fb_taken     = ft;
    fb.fb_not_taken = fnt;
    fb.fb_pc        = fpc;
    fb.jump_vec     = jv;
  endtask

  task automatic check(input string name, input bit rst, input Bpred_result e);
    bit ok;
    n_cmp++;
    if (!rst)          ok = (pred == '0);
    else if (e.valid)  ok = (pred == e);
    else               ok = (pred.valid == 1'b0);
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got v=%0b pc=%h hit=%0b tk=%0b npc=%h, want v=%0b pc=%h hit=%0b tk=%0b npc=%h",
               name, pred.valid, pred.pc, pred.hit, pred.taken, pred.npc,
               e.valid, e.pc, e.hit, e.taken, e.npc);
    end
  endtask

  function automatic vec_t mk(bit rst, bit fv, Address pc, bit fl, bit ft, bit fnt,
                              Address fpc, Address jv, bit ev, bit eh, bit et, Address enpc);
    vec_t v;
    v.rst = rst; v.fv = fv; v.pc = pc; v.fl = fl; v.ft = ft; v.fnt = fnt;
    v.fpc = fpc; v.jv = jv; v.ev = ev; v.eh = eh; v.et = et; v.enpc = enpc;
    return v;
  endfunction

  initial begin
    Bpred_result e;
    Bpred_result dummy;

    //                rst fv pc            fl ft fnt fpc        jv          ev eh et npc
    vecs.push_back(mk(0, 1, 32'h104,      0, 1, 0, 32'h104, 32'h999,  0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h100,      0, 0, 0, 32'h0,   32'h0,    1, 0, 0, 32'h101));
    vecs.push_back(mk(1, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,   32'h0,    1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h104, 32'h200,  0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h104,      0, 0, 0, 32'h0,   32'h0,    1, 1, 1, 32'h200));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'h104, 32'h0,    0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'h104, 32'h0,    0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h104,      0, 0, 0, 32'h0,   32'h0,    1, 1, 0, 32'h105));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'h104, 32'h0,    0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h104, 32'h200,  0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h104,      0, 0, 0, 32'h0,   32'h0,    1, 1, 0, 32'h105));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h104, 32'h200,  0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h104, 32'h200,  0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h104, 32'h200,  0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'h104, 32'h0,    0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h104,      0, 0, 0, 32'h0,   32'h0,    1, 1, 1, 32'h200));
    vecs.push_back(mk(1, 1, 32'h114,      0, 0, 0, 32'h0,   32'h0,    1, 0, 0, 32'h115));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'h114, 32'h0,    0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h104,      0, 0, 0, 32'h0,   32'h0,    1, 1, 1, 32'h200));
    vecs.push_back(mk(1, 1, 32'h108,      0, 1, 0, 32'h108, 32'h300,  1, 0, 0, 32'h109));
    vecs.push_back(mk(1, 1, 32'h108,      0, 0, 0, 32'h0,   32'h0,    1, 1, 1, 32'h300));
    vecs.push_back(mk(1, 1, 32'h104,      1, 0, 0, 32'h0,   32'h0,    0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h10C,      0, 1, 0, 32'h10C, 32'h500,  0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h104,      0, 0, 0, 32'h0,   32'h0,    1, 0, 0, 32'h105));
    vecs.push_back(mk(1, 1, 32'h10C,      0, 0, 0, 32'h0,   32'h0,    1, 0, 0, 32'h10D));

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].fv, vecs[k].pc, vecs[k].fl, vecs[k].ft, vecs[k].fnt,
            vecs[k].fpc, vecs[k].jv);
      dummy = m_step(vecs[k].rst, vecs[k].fv, vecs[k].pc, vecs[k].fl, vecs[k].ft,
                     vecs[k].fnt, vecs[k].fpc, vecs[k].jv);
      e = '0;
      e.valid = vecs[k].ev;
      e.pc    = vecs[k].pc;
      e.hit   = vecs[k].eh;
      e.taken = vecs[k].et;
      e.npc   = vecs[k].enpc;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), vecs[k].rst, e);
    end

    for (int n = 0; n < 3000; n++) begin
      bit     rst, fv, fl, ft, fnt;
      Address pc, fpc, jv;
      int     kind;
      rst  = ($urandom_range(0, 299) != 0);
      fv   = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 9) == 0);
      pc   = 32'h100 + 32'($urandom_range(0, 47));
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      fpc  = ($urandom_range(0, 2) == 0) ? pc : 32'h100 + 32'($urandom_range(0, 47));
      jv   = $urandom;
      kind = $urandom_range(0, 2);
      ft   = (kind == 1);
      fnt  = (kind == 2);
      drive(rst, fv, pc, fl, ft, fnt, fpc, jv);
      e = m_step(rst, fv, pc, fl, ft, fnt, fpc, jv);
      @(posedge clk);
      #1;
      check("random", rst, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
